// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI-slave frame receiver with length check and frame FIFO
module spi_frame_rx #(
    parameter int FIELD_W    = 32,
    parameter int NUM_FIELDS = 2,
    parameter int LSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            spi_clk,
    input  logic                            spi_en,
    input  logic                            spi_data,
    output logic [FIELD_W*NUM_FIELDS-1:0]   frame_data,
    output logic                            frame_valid,
    input  logic                            frame_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            frame_err,
    output logic                            overflow
);

    localparam int TOTAL = FIELD_W * NUM_FIELDS;
    localparam int CNT_W = $clog2(TOTAL + 2);
    localparam int POS_W = $clog2(TOTAL);
    localparam int BIT_W = $clog2(FIELD_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(TOTAL + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FIELD_W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, RECV} state_t;

    state_t             state, state_nxt;
    logic [2:0]         sclk_q, sen_q;
    logic [1:0]         sdat_q;
    logic               clk_rise, en_rise, en_fall;
    logic               start, judge, capture;
    logic [CNT_W-1:0]   count;
    logic [BIT_W-1:0]   bit_sel;
    logic [POS_W-1:0]   field_base, pos;
    logic [TOTAL-1:0]   shreg;
    logic               push_req, err_set;
    logic [TOTAL-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [LVL_W-1:0]   level;
    logic               full, pop, accept;

    // Synchronisers: clock/enable get a third flop for edge detect; data only needs to line up with s2
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            sen_q  <= '0;
            sdat_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            sen_q  <= {sen_q[1:0], spi_en};
            sdat_q <= {sdat_q[0], spi_data};
        end
    end

    assign clk_rise = sclk_q[1] & ~sclk_q[2];
    assign en_rise  = sen_q[1] & ~sen_q[2];
    assign en_fall  = ~sen_q[1] & sen_q[2];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: an enable rise always restarts, a fall ends the frame and triggers judgement
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        judge     = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (en_rise) begin
                    state_nxt = RECV;
                    start     = 1'b1;
                end
            end
            RECV: begin
                if (en_rise) begin
                    start = 1'b1;
                end else if (en_fall) begin
                    state_nxt = IDLE;
                    judge     = 1'b1;
                end else if (clk_rise && sen_q[1]) begin
                    capture = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit k lands at field_base + bit offset; MSB-first mode mirrors the offset inside each field
    assign pos = (LSB_FIRST != 0) ? field_base + POS_W'(bit_sel)
                                  : field_base + POS_W'(FIELD_W - 1) - POS_W'(bit_sel);

    // Deserialiser: place each captured bit directly, count saturates one past a full frame
    always_ff @(posedge clk) begin
        if (rst || start) begin
            count      <= '0;
            bit_sel    <= '0;
            field_base <= '0;
            shreg      <= '0;
        end else if (capture) begin
            if (count < CNT_FULL) begin
                shreg[pos] <= sdat_q[1];
                count      <= count + CNT_W'(1);
                if (bit_sel == BIT_LAST) begin
                    bit_sel    <= '0;
                    field_base <= field_base + POS_W'(FIELD_W);
                end else begin
                    bit_sel <= bit_sel + BIT_W'(1);
                end
            end else if (count == CNT_FULL) begin
                count <= CNT_OVER;
            end
        end
    end

    assign push_req = judge && (count == CNT_FULL);
    assign err_set  = judge && (count != '0) && (count != CNT_FULL);
    assign full     = (level == LVL_FULL);
    assign pop      = (level != '0) && frame_ready;
    assign accept   = push_req && (!full || pop);

    // Frame storage; a full FIFO still accepts when the head leaves on the same edge
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= shreg;
    end

    // FIFO pointers, level and the one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            frame_err <= err_set;
            overflow  <= push_req && full && !pop;
        end
    end

    assign frame_valid = (level != '0);
    assign frame_data  = frame_valid ? mem[rd_ptr] : '0;
    assign fifo_level  = level;

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - directed/random bench for spi_frame_rx with queue-based model
module tb_spi_frame_rx;

    logic        tb_clk = 1'b0;
    logic        rst, spi_clk, spi_en, spi_data, frame_ready, frame_ready2;
    logic [63:0] frame_data;
    logic        frame_valid, frame_err, overflow;
    logic [2:0]  fifo_level;
    logic [47:0] frame_data2;
    logic        frame_valid2, frame_err2, overflow2;
    logic [2:0]  fifo_level2;

    int errors = 0;
    int checks = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int model_ovf = 0;
    logic [63:0] q1[$];

    always #5 tb_clk = ~tb_clk;

    spi_frame_rx dut (
        .clk(tb_clk), .rst(rst), .spi_clk(spi_clk), .spi_en(spi_en), .spi_data(spi_data),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .fifo_level(fifo_level), .frame_err(frame_err), .overflow(overflow)
    );

    spi_frame_rx #(.FIELD_W(16), .NUM_FIELDS(3), .LSB_FIRST(0), .FIFO_DEPTH(4)) dut2 (
        .clk(tb_clk), .rst(rst), .spi_clk(spi_clk), .spi_en(spi_en), .spi_data(spi_data),
        .frame_data(frame_data2), .frame_valid(frame_valid2), .frame_ready(frame_ready2),
        .fifo_level(fifo_level2), .frame_err(frame_err2), .overflow(overflow2)
    );

    // Pulse counters sampled on the falling edge
    always @(negedge tb_clk) begin
        if (frame_err === 1'b1) err_cnt++;
        if (overflow === 1'b1)  ovf_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    task automatic start_frame();
        spi_en = 1'b1;
        wait_clks(3);
    endtask

    task automatic shift_bits(input int n, input logic [127:0] bits);
        for (int k = 0; k < n; k++) begin
            spi_data = bits[k];
            wait_clks(3);
            spi_clk = 1'b1;
            wait_clks(3);
            spi_clk = 1'b0;
        end
        spi_data = 1'b0;
    endtask

    task automatic end_frame();
        wait_clks(3);
        spi_en = 1'b0;
        wait_clks(6);
    endtask

    // Full 64-bit LSB-first frame; the model enqueues it unless its FIFO of 4 is full
    task automatic send64(input logic [63:0] v);
        start_frame();
        shift_bits(64, {64'b0, v});
        end_frame();
        if (q1.size() < 4) q1.push_back(v);
        else               model_ovf++;
    endtask

    task automatic pop_one();
        frame_ready = 1'b1;
        wait_clks(1);
        frame_ready = 1'b0;
    endtask

    initial begin
        logic [63:0]  v;
        logic [63:0]  exp_head;
        logic [127:0] bits;
        logic [47:0]  v48, exp2;
        int e0, o0;

        rst = 1'b1; spi_clk = 1'b0; spi_en = 1'b0; spi_data = 1'b0;
        frame_ready = 1'b0; frame_ready2 = 1'b0;
        wait_clks(3);
        check("rst_valid", 128'(frame_valid), 128'(0));
        check("rst_data",  128'(frame_data),  128'(0));
        check("rst_level", 128'(fifo_level),  128'(0));
        check("rst_err",   128'(frame_err),   128'(0));
        check("rst_ovf",   128'(overflow),    128'(0));
        rst = 1'b0;
        wait_clks(2);

        // Single-bit frame with exact push latency
        start_frame();
        shift_bits(64, 128'h1);
        wait_clks(3);
        spi_en = 1'b0;
        wait_clks(2);
        check("t1_valid_before", 128'(frame_valid), 128'(0));
        wait_clks(1);
        check("t1_valid", 128'(frame_valid), 128'(1));
        check("t1_data",  128'(frame_data),  128'h1);
        check("t1_err",   128'(frame_err),   128'(0));
        wait_clks(4);
        pop_one();
        check("t1_pop_valid", 128'(frame_valid), 128'(0));
        check("t1_pop_data",  128'(frame_data),  128'(0));

        // Two-field split and pop
        send64(64'h0000_0008_0000_000F);
        exp_head = q1.pop_front();
        check("t2_field0", 128'(frame_data[31:0]),  128'h0000_000F);
        check("t2_field1", 128'(frame_data[63:32]), 128'h0000_0008);
        check("t2_model",  128'(frame_data), 128'(exp_head));
        pop_one();
        check("t2_pop_valid", 128'(frame_valid), 128'(0));
        check("t2_pop_data",  128'(frame_data),  128'(0));

        // Random full frames
        for (int i = 0; i < 3; i++) begin
            v = {$urandom, $urandom};
            send64(v);
            exp_head = q1.pop_front();
            check("rand_data", 128'(frame_data), 128'(exp_head));
            pop_one();
        end

        // Length errors and empty toggle
        e0 = err_cnt;
        start_frame(); shift_bits(40, {$urandom, $urandom, $urandom, $urandom}); end_frame();
        check("t3_err40", 128'(err_cnt - e0), 128'(1));
        start_frame(); shift_bits(70, {$urandom, $urandom, $urandom, $urandom}); end_frame();
        check("t3_err70", 128'(err_cnt - e0), 128'(2));
        start_frame(); end_frame();
        check("t3_err0", 128'(err_cnt - e0), 128'(2));
        check("t3_level", 128'(fifo_level), 128'(0));

        // Overflow on the fifth frame
        o0 = ovf_cnt;
        model_ovf = 0;
        for (int i = 0; i < 5; i++) begin
            send64({$urandom, $urandom});
            check("t4_level", 128'(fifo_level), 128'((i < 4) ? i + 1 : 4));
            check("t4_ovf", 128'(ovf_cnt - o0), 128'(model_ovf));
        end
        for (int i = 0; i < 4; i++) begin
            exp_head = q1.pop_front();
            check("t4_drain", 128'(frame_data), 128'(exp_head));
            pop_one();
        end
        check("t4_empty", 128'(frame_valid), 128'(0));

        // Push into a full FIFO on the same edge as a pop
        for (int i = 0; i < 4; i++) send64({$urandom, $urandom});
        o0 = ovf_cnt;
        v = {$urandom, $urandom};
        start_frame();
        shift_bits(64, {64'b0, v});
        wait_clks(3);
        spi_en = 1'b0;
        wait_clks(2);
        frame_ready = 1'b1;
        wait_clks(1);
        frame_ready = 1'b0;
        void'(q1.pop_front());
        q1.push_back(v);
        wait_clks(4);
        check("t4b_level", 128'(fifo_level), 128'(4));
        check("t4b_ovf", 128'(ovf_cnt - o0), 128'(0));
        for (int i = 0; i < 4; i++) begin
            exp_head = q1.pop_front();
            check("t4b_drain", 128'(frame_data), 128'(exp_head));
            pop_one();
        end

        // Reset mid-frame with enable held high
        e0 = err_cnt;
        start_frame();
        shift_bits(20, {$urandom, $urandom, $urandom, $urandom});
        wait_clks(1);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        wait_clks(4);
        shift_bits(44, {$urandom, $urandom, $urandom, $urandom});
        end_frame();
        check("t5_err", 128'(err_cnt - e0), 128'(1));
        check("t5_level", 128'(fifo_level), 128'(0));
        v = {$urandom, $urandom};
        send64(v);
        exp_head = q1.pop_front();
        check("t5_next", 128'(frame_data), 128'(exp_head));
        pop_one();

        // MSB-first, three 16-bit fields on the second instance
        v48 = 48'h1234_ABCD_0F0F;
        bits = '0;
        for (int k = 0; k < 48; k++) bits[k] = v48[47 - k];
        exp2 = '0;
        for (int k = 0; k < 48; k++) exp2[(k / 16) * 16 + 15 - (k % 16)] = bits[k];
        e0 = err_cnt;
        start_frame(); shift_bits(48, bits); end_frame();
        check("t6_valid2", 128'(frame_valid2), 128'(1));
        check("t6_level2", 128'(fifo_level2), 128'(1));
        check("t6_model2", 128'(frame_data2), 128'(exp2));
        check("t6_const2", 128'(frame_data2), 128'h0F0F_ABCD_1234);
        check("t6_err1", 128'(err_cnt - e0), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
